// File: rtl/alu_seq_pkg.sv
// Shared state encoding, opcode constants and instruction field geometry
// for the ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        EXEC,
        WRITE,
        DONE
    } state_t;

    localparam logic [3:0] OP_NOP = 4'hF;

    // Field layout, MSB down: op[4] | dst[rw] | src1[rw] | imm_flag | src2/imm.
    function automatic int op_lsb(input int iw);
        return iw - 4;
    endfunction

    function automatic int dst_lsb(input int iw, input int rw);
        return iw - 4 - rw;
    endfunction

    function automatic int src1_lsb(input int iw, input int rw);
        return iw - 4 - 2 * rw;
    endfunction

    function automatic int imm_flag_pos(input int iw, input int rw);
        return iw - 5 - 2 * rw;
    endfunction

    // The immediate / src2 field fills everything below the flag bit.
    function automatic int imm_width(input int iw, input int rw);
        return iw - 5 - 2 * rw;
    endfunction

endpackage

// File: rtl/alu_seq_fsm_if.sv
// Instruction handshake plus the datapath strobe bundle of the sequencer.
interface alu_seq_fsm_if
    import alu_seq_pkg::*;
#(
    parameter int IW       = 16,
    parameter int NUM_REGS = 6
);
    localparam int RW   = $clog2(NUM_REGS);
    localparam int IMMW = imm_width(IW, RW);

    logic                instr_valid;
    logic [IW-1:0]       instr;
    logic                instr_ready;
    logic [3:0]          alu_op;
    logic                alu_in1;
    logic                alu_in2;
    logic                alu_outlatch;
    logic                alu_out_en;
    logic                imm_out_en;
    logic [IMMW-1:0]     imm;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic                pc_inc;
    logic                done;
    logic                illegal;

    // Instruction source: offers words, observes strobes.
    modport master (
        output instr_valid, instr,
        input  instr_ready, alu_op, alu_in1, alu_in2, alu_outlatch, alu_out_en,
               imm_out_en, imm, reg_in, reg_out, pc_inc, done, illegal
    );

    // Sequencer: accepts words, drives strobes.
    modport slave (
        input  instr_valid, instr,
        output instr_ready, alu_op, alu_in1, alu_in2, alu_outlatch, alu_out_en,
               imm_out_en, imm, reg_in, reg_out, pc_inc, done, illegal
    );

endinterface

// File: rtl/alu_instr_decode.sv
// Splits an instruction word into its fields and flags illegal encodings.
module alu_instr_decode
    import alu_seq_pkg::*;
#(
    parameter int IW       = 16,
    parameter int NUM_REGS = 6,
    parameter int NUM_OPS  = 10,
    parameter int RW       = $clog2(NUM_REGS),
    parameter int IMMW     = imm_width(IW, RW)
) (
    input  logic [IW-1:0]   instr,
    output logic [3:0]      op,
    output logic [RW-1:0]   dst,
    output logic [RW-1:0]   src1,
    output logic            imm_flag,
    output logic [IMMW-1:0] imm,
    output logic            illegal
);
    localparam int OP_LSB   = op_lsb(IW);
    localparam int DST_LSB  = dst_lsb(IW, RW);
    localparam int SRC1_LSB = src1_lsb(IW, RW);
    localparam int FLAG_POS = imm_flag_pos(IW, RW);

    logic [RW-1:0] src2;
    logic          bad_op;
    logic          bad_reg;

    // Field extraction; src2 is only a register index when imm_flag is clear.
    always_comb begin
        op       = instr[OP_LSB +: 4];
        dst      = instr[DST_LSB +: RW];
        src1     = instr[SRC1_LSB +: RW];
        imm_flag = instr[FLAG_POS];
        imm      = instr[IMMW-1:0];
        src2     = imm[RW-1:0];
        bad_op   = (32'(op) >= NUM_OPS) && (op != OP_NOP);
        bad_reg  = (32'(dst) >= NUM_REGS) || (32'(src1) >= NUM_REGS)
                || (!imm_flag && (32'(src2) >= NUM_REGS));
        illegal  = bad_op || bad_reg;
    end

endmodule

// File: rtl/alu_seq_fsm.sv
// Accepts one instruction per handshake and sequences operand fetch, ALU
// execution, write-back and PC increment. All outputs are registered and
// decoded from the state being entered, so they behave as Moore outputs.
module alu_seq_fsm
    import alu_seq_pkg::*;
#(
    parameter int IW       = 16,
    parameter int NUM_REGS = 6,
    parameter int NUM_OPS  = 10,
    parameter int ALU_LAT  = 1
) (
    input logic          clk,
    input logic          rst,
    alu_seq_fsm_if.slave bus
);
    localparam int RW   = $clog2(NUM_REGS);
    localparam int IMMW = imm_width(IW, RW);
    localparam int CW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] EXEC_LOAD = CW'(ALU_LAT - 1);

    function automatic logic [NUM_REGS-1:0] onehot(input logic [RW-1:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [3:0]      dec_op;
    logic [RW-1:0]   dec_dst;
    logic [RW-1:0]   dec_src1;
    logic            dec_imm_flag;
    logic [IMMW-1:0] dec_imm;
    logic            dec_illegal;

    alu_instr_decode #(
        .IW       (IW),
        .NUM_REGS (NUM_REGS),
        .NUM_OPS  (NUM_OPS),
        .RW       (RW),
        .IMMW     (IMMW)
    ) u_decode (
        .instr    (bus.instr),
        .op       (dec_op),
        .dst      (dec_dst),
        .src1     (dec_src1),
        .imm_flag (dec_imm_flag),
        .imm      (dec_imm),
        .illegal  (dec_illegal)
    );

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [RW-1:0]       dst_q, dst_d;
    logic [RW-1:0]       src1_q, src1_d;
    logic                imm_flag_q, imm_flag_d;
    logic [IMMW-1:0]     imm_q, imm_d;
    logic                bad_q, bad_d;
    logic                instr_ready_q, instr_ready_d;
    logic                alu_in1_q, alu_in1_d;
    logic                alu_in2_q, alu_in2_d;
    logic                alu_outlatch_q, alu_outlatch_d;
    logic                alu_out_en_q, alu_out_en_d;
    logic                imm_out_en_q, imm_out_en_d;
    logic [NUM_REGS-1:0] reg_in_q, reg_in_d;
    logic [NUM_REGS-1:0] reg_out_q, reg_out_d;
    logic                pc_inc_q, pc_inc_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    // Next state, instruction latch and the outputs of the state being entered.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        dst_d          = dst_q;
        src1_d         = src1_q;
        imm_flag_d     = imm_flag_q;
        imm_d          = imm_q;
        bad_d          = bad_q;
        instr_ready_d  = 1'b0;
        alu_in1_d      = 1'b0;
        alu_in2_d      = 1'b0;
        alu_outlatch_d = 1'b0;
        alu_out_en_d   = 1'b0;
        imm_out_en_d   = 1'b0;
        reg_in_d       = '0;
        reg_out_d      = '0;
        pc_inc_d       = 1'b0;
        done_d         = 1'b0;
        illegal_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    op_d       = dec_op;
                    dst_d      = dec_dst;
                    src1_d     = dec_src1;
                    imm_flag_d = dec_imm_flag;
                    imm_d      = dec_imm;
                    bad_d      = dec_illegal;
                    state_d    = (dec_illegal || dec_op == OP_NOP) ? DONE : FETCH_A;
                end
            end
            FETCH_A: state_d = FETCH_B;
            FETCH_B: begin
                state_d = EXEC;
                cnt_d   = EXEC_LOAD;
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            IDLE: instr_ready_d = 1'b1;
            FETCH_A: begin
                reg_out_d = onehot(src1_d);
                alu_in1_d = 1'b1;
            end
            FETCH_B: begin
                alu_in2_d = 1'b1;
                if (imm_flag_d) begin
                    imm_out_en_d = 1'b1;
                end else begin
                    reg_out_d = onehot(imm_d[RW-1:0]);
                end
            end
            EXEC: alu_outlatch_d = (cnt_d == '0);
            WRITE: begin
                alu_out_en_d = 1'b1;
                reg_in_d     = onehot(dst_d);
            end
            DONE: begin
                done_d    = 1'b1;
                pc_inc_d  = 1'b1;
                illegal_d = bad_d;
            end
            default: ;
        endcase
    end

    // State, latched instruction and registered outputs; rst low forces IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            dst_q          <= '0;
            src1_q         <= '0;
            imm_flag_q     <= 1'b0;
            imm_q          <= '0;
            bad_q          <= 1'b0;
            instr_ready_q  <= 1'b1;
            alu_in1_q      <= 1'b0;
            alu_in2_q      <= 1'b0;
            alu_outlatch_q <= 1'b0;
            alu_out_en_q   <= 1'b0;
            imm_out_en_q   <= 1'b0;
            reg_in_q       <= '0;
            reg_out_q      <= '0;
            pc_inc_q       <= 1'b0;
            done_q         <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every flop sample pre-edge values, as real flops do.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            dst_q          <= dst_d;
            src1_q         <= src1_d;
            imm_flag_q     <= imm_flag_d;
            imm_q          <= imm_d;
            bad_q          <= bad_d;
            instr_ready_q  <= instr_ready_d;
            alu_in1_q      <= alu_in1_d;
            alu_in2_q      <= alu_in2_d;
            alu_outlatch_q <= alu_outlatch_d;
            alu_out_en_q   <= alu_out_en_d;
            imm_out_en_q   <= imm_out_en_d;
            reg_in_q       <= reg_in_d;
            reg_out_q      <= reg_out_d;
            pc_inc_q       <= pc_inc_d;
            done_q         <= done_d;
            illegal_q      <= illegal_d;
        end
    end

    assign bus.instr_ready  = instr_ready_q;
    assign bus.alu_op       = op_q;
    assign bus.alu_in1      = alu_in1_q;
    assign bus.alu_in2      = alu_in2_q;
    assign bus.alu_outlatch = alu_outlatch_q;
    assign bus.alu_out_en   = alu_out_en_q;
    assign bus.imm_out_en   = imm_out_en_q;
    assign bus.imm          = imm_q;
    assign bus.reg_in       = reg_in_q;
    assign bus.reg_out      = reg_out_q;
    assign bus.pc_inc       = pc_inc_q;
    assign bus.done         = done_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Bench for alu_seq_fsm: two instances (ALU_LAT=1 and ALU_LAT=3) receive the
// same instruction stream and are compared cycle by cycle against a timeline
// model built from the instruction rules.
module tb_alu_seq_fsm;

    typedef struct packed {
        logic       ready;
        logic       in1;
        logic       in2;
        logic       outlatch;
        logic       out_en;
        logic       imm_en;
        logic       pc_inc;
        logic       done;
        logic       illegal;
        logic [3:0] alu_op;
        logic [4:0] imm;
        logic [5:0] reg_in;
        logic [5:0] reg_out;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        int          lat1;     // accept-to-done cycles with ALU_LAT=1
        logic        illegal;
        logic [5:0]  wr;       // register written back
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tb_valid;
    logic [15:0] tb_instr;
    int          n_tests = 0;
    int          n_fail  = 0;
    obs_t        o1, o3;
    vec_t        vecs[10];

    always #5 clk = ~clk;

    alu_seq_fsm_if #(.IW(16), .NUM_REGS(6)) bus1 ();
    alu_seq_fsm_if #(.IW(16), .NUM_REGS(6)) bus3 ();

    assign bus1.instr_valid = tb_valid;
    assign bus1.instr       = tb_instr;
    assign bus3.instr_valid = tb_valid;
    assign bus3.instr       = tb_instr;

    alu_seq_fsm #(.IW(16), .NUM_REGS(6), .NUM_OPS(10), .ALU_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    alu_seq_fsm #(.IW(16), .NUM_REGS(6), .NUM_OPS(10), .ALU_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    assign o1 = {bus1.instr_ready, bus1.alu_in1, bus1.alu_in2, bus1.alu_outlatch,
                 bus1.alu_out_en, bus1.imm_out_en, bus1.pc_inc, bus1.done, bus1.illegal,
                 bus1.alu_op, bus1.imm, bus1.reg_in, bus1.reg_out};
    assign o3 = {bus3.instr_ready, bus3.alu_in1, bus3.alu_in2, bus3.alu_outlatch,
                 bus3.alu_out_en, bus3.imm_out_en, bus3.pc_inc, bus3.done, bus3.illegal,
                 bus3.alu_op, bus3.imm, bus3.reg_in, bus3.reg_out};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs c cycles after the accept edge (c >= 1). op_chk says
    // whether alu_op is meaningful in that cycle (EXEC only).
    function automatic obs_t model(input logic [15:0] ins, input int lat, input int c,
                                   output bit op_chk);
        obs_t e = '0;
        int   w, op, dst, src1, flag, fld, src2;
        bit   legal, alu;
        w      = int'(ins);
        op     = (w >> 12) & 15;
        dst    = (w >> 9) & 7;
        src1   = (w >> 6) & 7;
        flag   = (w >> 5) & 1;
        fld    = w & 31;
        src2   = fld & 7;
        legal  = !(op >= 10 && op != 15) && dst < 6 && src1 < 6 && (flag == 1 || src2 < 6);
        alu    = legal && op != 15;
        op_chk = 1'b0;
        e.alu_op = 4'(op);
        e.imm    = 5'(fld);
        if (!alu) begin
            if (c == 1) begin
                e.done    = 1'b1;
                e.pc_inc  = 1'b1;
                e.illegal = !legal;
            end else begin
                e.ready = 1'b1;
            end
        end else if (c == 1) begin
            e.reg_out = 6'(1 << src1);
            e.in1     = 1'b1;
        end else if (c == 2) begin
            e.in2 = 1'b1;
            if (flag == 1) e.imm_en = 1'b1;
            else           e.reg_out = 6'(1 << src2);
        end else if (c <= 2 + lat) begin
            op_chk     = 1'b1;
            e.outlatch = (c == 2 + lat);
        end else if (c == 3 + lat) begin
            e.out_en = 1'b1;
            e.reg_in = 6'(1 << dst);
        end else if (c == 4 + lat) begin
            e.done   = 1'b1;
            e.pc_inc = 1'b1;
        end else begin
            e.ready = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t idle_obs();
        obs_t e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Full-vector compare; opcode and immediate are only meaningful while used.
    task automatic cmp_obs(input string name, input obs_t act, input obs_t exp, input bit op_chk);
        if (!op_chk) begin
            act.alu_op = '0;
            exp.alu_op = '0;
        end
        if (!exp.imm_en) begin
            act.imm = '0;
            exp.imm = '0;
        end
        check(name, 32'(act), 32'(exp));
    endtask

    // Offer one instruction (called just after a negedge with both DUTs idle)
    // and compare both instances for ncyc cycles. With keep set, a NOP stays
    // offered during FETCH_A/FETCH_B and must be ignored.
    task automatic run_trace(input string tag, input logic [15:0] ins, input int ncyc, input bit keep);
        obs_t e;
        bit   oc;
        tb_instr = ins;
        tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            e = model(ins, 1, c, oc);
            cmp_obs($sformatf("%s lat1 c%0d", tag, c), o1, e, oc);
            e = model(ins, 3, c, oc);
            cmp_obs($sformatf("%s lat3 c%0d", tag, c), o3, e, oc);
            if (keep && c < 3) begin
                tb_instr = 16'hF000;
                tb_valid = 1'b1;
            end else begin
                tb_valid = 1'b0;
            end
        end
    endtask

    // Table vector: measure done latency, illegal flag and write-back target.
    task automatic run_vec(input int idx, input vec_t v);
        int         lat1 = 0;
        int         lat3 = 0;
        logic       ill1 = 1'b0;
        logic       ill3 = 1'b0;
        logic [5:0] wr1  = '0;
        int         exp3;
        tb_instr = v.instr;
        tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (o1.done && lat1 == 0) begin
                lat1 = c;
                ill1 = o1.illegal;
            end
            if (o3.done && lat3 == 0) begin
                lat3 = c;
                ill3 = o3.illegal;
            end
            wr1 |= o1.reg_in;
        end
        exp3 = (v.lat1 == 1) ? 1 : v.lat1 + 2;
        check($sformatf("vec%0d latency lat1", idx), 32'(lat1), 32'(v.lat1));
        check($sformatf("vec%0d latency lat3", idx), 32'(lat3), 32'(exp3));
        check($sformatf("vec%0d illegal lat1", idx), 32'(ill1), 32'(v.illegal));
        check($sformatf("vec%0d illegal lat3", idx), 32'(ill3), 32'(v.illegal));
        check($sformatf("vec%0d writeback", idx), 32'(wr1), 32'(v.wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h9002, 5, 1'b0, 6'b000001};
        vecs[1] = '{16'h9475, 5, 1'b0, 6'b000100};
        vecs[2] = '{16'h01C0, 1, 1'b1, 6'b000000};
        vecs[3] = '{16'hF000, 1, 1'b0, 6'b000000};
        vecs[4] = '{16'hA000, 1, 1'b1, 6'b000000};
        vecs[5] = '{16'h0A00, 5, 1'b0, 6'b100000};
        vecs[6] = '{16'h0006, 1, 1'b1, 6'b000000};
        vecs[7] = '{16'h0026, 5, 1'b0, 6'b000001};
        vecs[8] = '{16'hEC00, 1, 1'b1, 6'b000000};
        vecs[9] = '{16'hFE00, 1, 1'b1, 6'b000000};

        // Reset held with an instruction offered: nothing may be accepted.
        rst      = 1'b0;
        tb_valid = 1'b1;
        tb_instr = 16'h9002;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            cmp_obs($sformatf("reset lat1 c%0d", i), o1, idle_obs(), 1'b0);
            cmp_obs($sformatf("reset lat3 c%0d", i), o3, idle_obs(), 1'b0);
        end
        tb_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        cmp_obs("post reset lat1", o1, idle_obs(), 1'b0);
        cmp_obs("post reset lat3", o3, idle_obs(), 1'b0);

        // Directed cycle-by-cycle sequences.
        run_trace("9002", 16'h9002, 8, 1'b0);
        run_trace("9475", 16'h9475, 8, 1'b1);
        run_trace("01C0", 16'h01C0, 3, 1'b0);
        run_trace("F000", 16'hF000, 3, 1'b0);
        run_trace("9002 hold", 16'h9002, 8, 1'b1);

        // Table-driven latency / flag / write-back vectors.
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset during EXEC aborts the instruction with no write-back or done.
        tb_instr = 16'h9002;
        tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort pre-reset outlatch lat1", 32'(o1.outlatch), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            cmp_obs($sformatf("abort lat1 c%0d", c), o1, idle_obs(), 1'b0);
            cmp_obs($sformatf("abort lat3 c%0d", c), o3, idle_obs(), 1'b0);
        end

        // Random instructions against the timeline model.
        for (int n = 0; n < 150; n++) begin
            run_trace($sformatf("rnd%0d", n), 16'($urandom), 8, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
